// File: rtl/bitmask_index_serializer_if.sv
// rtl/bitmask_index_serializer_if.sv - mask-in / index-out handshake bundle
// slave is the serializer side; master is the producer/consumer side.
interface bitmask_index_serializer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [INDEX_WIDTH-1:0] out_idx;
   logic                   out_last;
   logic [INDEX_WIDTH-1:0] out_seq;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_seq
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_seq
   );
endinterface

// File: rtl/bitmask_index_serializer.sv
// rtl/bitmask_index_serializer.sv - walks a mask word, one 1-based set-bit index per beat
// Highest bit first; an empty word yields a single beat with index 0.
module bitmask_index_serializer #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
) (
   input  logic clk,
   input  logic rst,
   bitmask_index_serializer_if.slave bus
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0]  mask, mask_nxt;
   logic [INDEX_WIDTH-1:0] seq, seq_nxt;
   logic [INDEX_WIDTH-1:0] lead_idx;
   logic [DATA_WIDTH-1:0]  lead_bit;
   logic                   single;
   logic                   in_ready_c;
   logic                   out_valid_c;

   // Ascending scan so the last hit wins: that is the highest set bit.
   always_comb begin
      lead_idx = '0;
      lead_bit = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         if (mask[j]) begin
            lead_idx = INDEX_WIDTH'(j + 1);
            lead_bit = DATA_WIDTH'(1) << j;
         end
      end
   end

   assign single = ((mask & (mask - DATA_WIDTH'(1))) == '0);

   always_comb begin
      state_nxt   = state;
      mask_nxt    = mask;
      seq_nxt     = seq;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = ~rst;
            if (bus.in_valid) begin
               mask_nxt  = bus.in_data;
               seq_nxt   = '0;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               mask_nxt = mask & ~lead_bit;
               seq_nxt  = seq + INDEX_WIDTH'(1);
               if (single) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mask  <= '0;
         seq   <= '0;
      end else begin
         state <= state_nxt;
         mask  <= mask_nxt;
         seq   <= seq_nxt;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_idx   = lead_idx;
   assign bus.out_last  = single;
   assign bus.out_seq   = seq;

endmodule

// File: tb/tb_bitmask_index_serializer.sv
// tb/tb_bitmask_index_serializer.sv - directed bench with expected-beat scoreboard
// Inputs change 1ns after the rising edge; outputs are observed on the falling edge.
module tb_bitmask_index_serializer;

   typedef struct packed {
      logic [3:0] idx;
      logic [3:0] seq;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bitmask_index_serializer_if #(.DATA_WIDTH(8)) bus ();

   bitmask_index_serializer #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    words_accepted = 0;
   int    lasts_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input logic [7:0] d);
      int pop;
      int n;
      beat_t b;
      pop = 0;
      for (int j = 0; j < 8; j++) if (d[j]) pop++;
      if (pop == 0) begin
         b.idx = 4'd0; b.seq = 4'd0; b.last = 1'b1;
         exp_q.push_back(b);
      end else begin
         n = 0;
         for (int j = 7; j >= 0; j--) begin
            if (d[j]) begin
               b.idx  = 4'(j + 1);
               b.seq  = 4'(n);
               b.last = (n == pop - 1);
               exp_q.push_back(b);
               n++;
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] d, output int waits);
      bit acc;
      acc   = 1'b0;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!acc && waits < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (acc) push_expected(d);
         @(posedge clk);
         #1;
         waits++;
      end
      bus.in_valid = 1'b0;
      check("accept_timeout", 32'(acc), 32'd1);
      if (acc) words_accepted++;
   endtask

   // mode 0: out_ready high; 1: out_ready pattern 1,0,0,1; 2: alternating with in_valid noise
   task automatic run_word(input int mode);
      bit done;
      int k;
      done = 1'b0;
      k = 0;
      while (!done && k < 200) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: bus.out_ready = k[0];
         endcase
         if (mode == 2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
         end
         @(negedge clk);
         if (k == 0) check("first_beat_latency", 32'(bus.out_valid), 32'd1);
         if (bus.out_valid && bus.out_ready && bus.out_last) done = 1'b1;
         @(posedge clk);
         #1;
         k++;
      end
      bus.in_valid = 1'b0;
      check("drain_timeout", 32'(done), 32'd1);
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Beat monitor: scoreboard compare, stall stability, ordering, handshake exclusivity.
   bit         stall_pending = 1'b0;
   logic [3:0] held_idx, held_seq, prev_idx;
   logic       held_last;
   beat_t      got;

   always @(negedge clk) begin
      if (rst) begin
         stall_pending = 1'b0;
      end else begin
         if (stall_pending) begin
            check("valid_drop", 32'(bus.out_valid), 32'd1);
            check("stall_idx", 32'(bus.out_idx), 32'(held_idx));
            check("stall_seq", 32'(bus.out_seq), 32'(held_seq));
            check("stall_last", 32'(bus.out_last), 32'(held_last));
         end
         check("ready_valid_excl", 32'(bus.out_valid && bus.in_ready), 32'd0);
         if (bus.out_valid && bus.out_ready) begin
            check("unexpected_beat", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               got = exp_q.pop_front();
               check("beat_idx", 32'(bus.out_idx), 32'(got.idx));
               check("beat_seq", 32'(bus.out_seq), 32'(got.seq));
               check("beat_last", 32'(bus.out_last), 32'(got.last));
            end
            if (bus.out_seq != 4'd0) check("idx_nonincreasing", 32'(bus.out_idx <= prev_idx), 32'd1);
            prev_idx = bus.out_idx;
            if (bus.out_last) lasts_seen++;
            stall_pending = 1'b0;
         end else if (bus.out_valid) begin
            stall_pending = 1'b1;
            held_idx  = bus.out_idx;
            held_seq  = bus.out_seq;
            held_last = bus.out_last;
         end else begin
            stall_pending = 1'b0;
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;

      bus.out_ready = 1'b1;
      send(8'b1010_0100, w);
      run_word(0);

      send(8'h00, w);
      run_word(0);

      send(8'hFF, w);
      run_word(1);

      // Back-to-back: in_valid stays high, second word must wait for the IDLE cycle.
      bus.out_ready = 1'b1;
      send(8'h01, w);
      send(8'h80, w);
      check("b2b_gap", 32'(w), 32'd2);
      run_word(0);

      send(8'b0010_0100, w);
      run_word(2);

      // Reset after the first beat of 0x60 discards index 6.
      bus.out_ready = 1'b1;
      send(8'b0110_0000, w);
      @(negedge clk);
      check("pre_rst_idx", 32'(bus.out_idx), 32'd7);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready_held", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      words_accepted--;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (4) begin
         @(negedge clk);
         check("no_residual_beat", 32'(bus.out_valid), 32'd0);
      end

      @(negedge clk);
      check("one_last_per_word", 32'(lasts_seen), 32'(words_accepted));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
